// File: rtl/blc_pkg.sv
// Shared definitions for the black-level (BLC) blocks: OB FSM states,
// Bayer channel codes and bayerFormat selectors.
package blc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACC      = 2'd1,
        ST_WAIT_EOF = 2'd2,
        ST_UPDATE   = 2'd3
    } ob_state_t;

    localparam int unsigned NUM_CH = 4;

    localparam logic [1:0] CH_R  = 2'd0;
    localparam logic [1:0] CH_GR = 2'd1;
    localparam logic [1:0] CH_GB = 2'd2;
    localparam logic [1:0] CH_B  = 2'd3;

    localparam int unsigned BAYER_RGGB = 0;
    localparam int unsigned BAYER_GRBG = 1;
    localparam int unsigned BAYER_GBRG = 2;
    localparam int unsigned BAYER_BGGR = 3;

endpackage

// File: rtl/blc_bayer_pos.sv
// Bayer position tracker: row/column parity from DVP sync and channel decode.
// Shared with the BLC datapath so both classify pixels identically.
module blc_bayer_pos
    import blc_pkg::*;
#(
    parameter int unsigned bayerFormat = BAYER_RGGB
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       href,
    input  logic       vsync,
    output logic [1:0] channel_c,
    output logic       href_fall_c
);

    logic col;
    logic row;
    logic href_d;

    assign href_fall_c = href_d & ~href;
    assign channel_c   = 2'(bayerFormat) ^ {row, col};

    // Column toggles per valid pixel; row toggles at end of each line, reset per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col    <= 1'b0;
            row    <= 1'b0;
            href_d <= 1'b0;
        end else begin
            href_d <= href;
            col    <= href ? ~col : 1'b0;
            if (vsync) begin
                row <= 1'b0;
            end else if (href_fall_c) begin
                row <= ~row;
            end
        end
    end

endmodule

// File: rtl/blc_ob_ctrl.sv
// Optical-black controller: averages the top OB_ROWS lines per Bayer channel
// and publishes black levels at end of frame. Optional IIR smoothing: BLC_OB_CTRL_IIR_EN.
module blc_ob_ctrl
    import blc_pkg::*;
#(
    parameter int unsigned bits        = 8,
    parameter int unsigned width       = 2048,
    parameter int unsigned height      = 2048,
    parameter int unsigned bayerFormat = BAYER_RGGB,
    parameter int unsigned OB_ROWS     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            href_i,
    input  logic            vsync_i,
    input  logic [bits-1:0] pixel_i,
    input  logic            manual_en_i,
    input  logic [bits-1:0] rMan_i,
    input  logic [bits-1:0] grMan_i,
    input  logic [bits-1:0] gbMan_i,
    input  logic [bits-1:0] bMan_i,
    output logic [bits-1:0] rMean_o,
    output logic [bits-1:0] grMean_o,
    output logic [bits-1:0] gbMean_o,
    output logic [bits-1:0] bMean_o,
    output logic            mean_valid_o,
    output logic            busy_o,
    output logic            abort_o
);

    // Each channel sees OB_ROWS*width/4 pixels, so the mean is a pure shift.
    localparam int unsigned S  = $clog2(OB_ROWS * width) - 2;
    localparam int unsigned AW = bits + S;
    localparam int unsigned LW = $clog2(OB_ROWS) + 1;

    if ((width & (width - 1)) != 0 || width < 2) begin : g_bad_width
        $error("blc_ob_ctrl: width must be a power of two >= 2");
    end
    if ((OB_ROWS & (OB_ROWS - 1)) != 0 || OB_ROWS < 2) begin : g_bad_ob_rows
        $error("blc_ob_ctrl: OB_ROWS must be a power of two >= 2");
    end
    if (height < OB_ROWS) begin : g_bad_height
        $error("blc_ob_ctrl: height must be at least OB_ROWS");
    end

    ob_state_t       state;
    ob_state_t       state_nx;
    logic            vsync_d;
    logic            vsync_rise_c;
    logic            vsync_fall_c;
    logic [1:0]      channel_c;
    logic            href_fall_c;
    logic [LW-1:0]   line_cnt;
    logic [AW-1:0]   acc  [NUM_CH];
    logic [bits-1:0] lvl  [NUM_CH];
    logic [bits-1:0] man  [NUM_CH];
    logic [bits-1:0] meas [NUM_CH];
    logic [bits-1:0] upd  [NUM_CH];
    logic            clear_c;
    logic            acc_en_c;
    logic            cnt_inc_c;
    logic            load_c;
    logic            abort_nx;
    logic            lines_done_c;

    blc_bayer_pos #(
        .bayerFormat (bayerFormat)
    ) u_pos (
        .clk         (clk),
        .rst         (rst),
        .href        (href_i),
        .vsync       (vsync_i),
        .channel_c   (channel_c),
        .href_fall_c (href_fall_c)
    );

    assign vsync_rise_c = vsync_i & ~vsync_d;
    assign vsync_fall_c = ~vsync_i & vsync_d;

`ifdef BLC_OB_CTRL_IIR_EN
    // out + ((meas - out) >>> 2); the step lies between out and meas so it never wraps.
    function automatic logic [bits-1:0] iir_step(input logic [bits-1:0] cur,
                                                 input logic [bits-1:0] meas_v);
        logic signed [bits:0] step;
        step = ($signed({1'b0, meas_v}) - $signed({1'b0, cur})) >>> 2;
        return bits'($signed({1'b0, cur}) + step);
    endfunction
`endif

    always_comb begin
        man[CH_R]  = rMan_i;
        man[CH_GR] = grMan_i;
        man[CH_GB] = gbMan_i;
        man[CH_B]  = bMan_i;
    end

    // Candidate output levels for the next update.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            meas[i] = bits'(acc[i] >> S);
`ifdef BLC_OB_CTRL_IIR_EN
            upd[i] = mean_valid_o ? iir_step(lvl[i], meas[i]) : meas[i];
`else
            upd[i] = meas[i];
`endif
            if (manual_en_i) begin
                upd[i] = man[i];
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nx     = state;
        clear_c      = 1'b0;
        acc_en_c     = 1'b0;
        cnt_inc_c    = 1'b0;
        load_c       = 1'b0;
        abort_nx     = 1'b0;
        lines_done_c = href_fall_c && (line_cnt == LW'(OB_ROWS - 1));
        unique case (state)
            ST_IDLE: begin
                if (vsync_fall_c) begin
                    state_nx = ST_ACC;
                    clear_c  = 1'b1;
                end
            end
            ST_ACC: begin
                acc_en_c  = href_i;
                cnt_inc_c = href_fall_c;
                if (vsync_rise_c) begin
                    if (lines_done_c) begin
                        state_nx = ST_UPDATE;
                        load_c   = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                        abort_nx = 1'b1;
                    end
                end else if (lines_done_c) begin
                    state_nx = ST_WAIT_EOF;
                end
            end
            ST_WAIT_EOF: begin
                if (vsync_rise_c) begin
                    state_nx = ST_UPDATE;
                    load_c   = 1'b1;
                end
            end
            ST_UPDATE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            vsync_d  <= 1'b0;
            line_cnt <= '0;
            busy_o   <= 1'b0;
            abort_o  <= 1'b0;
        end else begin
            state   <= state_nx;
            vsync_d <= vsync_i;
            busy_o  <= (state_nx == ST_ACC);
            abort_o <= abort_nx;
            if (clear_c) begin
                line_cnt <= '0;
            end else if (cnt_inc_c) begin
                line_cnt <= line_cnt + LW'(1);
            end
        end
    end

    // Per-channel OB sums; sized so OB_ROWS*width/4 full-scale pixels cannot overflow.
    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc[i] <= '0;
            end
        end else if (acc_en_c) begin
            acc[channel_c] <= acc[channel_c] + AW'(pixel_i);
        end
    end

    // Levels change only when the frame ends, so the BLC never sees a mid-frame step.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                lvl[i] <= '0;
            end
            mean_valid_o <= 1'b0;
        end else if (load_c) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                lvl[i] <= upd[i];
            end
            mean_valid_o <= 1'b1;
        end
    end

    assign rMean_o  = lvl[CH_R];
    assign grMean_o = lvl[CH_GR];
    assign gbMean_o = lvl[CH_GB];
    assign bMean_o  = lvl[CH_B];

endmodule

// File: tb/tb_blc_ob_ctrl.sv
// Scoreboard bench for blc_ob_ctrl: frames are generated with $urandom, a
// frame-level reference model predicts each end-of-frame result.
module tb_blc_ob_ctrl;

    localparam int BITS = 8;
    localparam int W    = 16;
    localparam int H    = 8;
    localparam int OB   = 2;
    localparam int BF   = 0;
    localparam int NPIX = OB * W / 4;

    typedef struct packed {
        logic       abort;
        logic       valid;
        logic [7:0] r;
        logic [7:0] gr;
        logic [7:0] gb;
        logic [7:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       href;
    logic       vsync;
    logic [7:0] pixel;
    logic       manual_en;
    logic [7:0] r_man, gr_man, gb_man, b_man;
    logic [7:0] r_mean, gr_mean, gb_mean, b_mean;
    logic       mean_valid, busy, abort;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference model state (frame level)
    int m_lvl[4];
    int m_sum[4];
    bit m_valid;
    bit m_armed;
    int m_lines;

    always #5 clk = ~clk;

    blc_ob_ctrl #(
        .bits        (BITS),
        .width       (W),
        .height      (H),
        .bayerFormat (BF),
        .OB_ROWS     (OB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .href_i       (href),
        .vsync_i      (vsync),
        .pixel_i      (pixel),
        .manual_en_i  (manual_en),
        .rMan_i       (r_man),
        .grMan_i      (gr_man),
        .gbMan_i      (gb_man),
        .bMan_i       (b_man),
        .rMean_o      (r_mean),
        .grMean_o     (gr_mean),
        .gbMean_o     (gb_mean),
        .bMean_o      (b_mean),
        .mean_valid_o (mean_valid),
        .busy_o       (busy),
        .abort_o      (abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div4(input int d);
        return (d >= 0) ? d / 4 : -((3 - d) / 4);
    endfunction

    function automatic int man_of(input int ch);
        case (ch)
            0:       return int'(r_man);
            1:       return int'(gr_man);
            2:       return int'(gb_man);
            default: return int'(b_man);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lvl[i] = 0;
            m_sum[i] = 0;
        end
        m_valid = 0;
        m_armed = 0;
        m_lines = 0;
    endtask

    // Monitor: on reset, on every sampled vsync rise, and on every other cycle.
    exp_t mon_last = '0;
    logic mon_vs_prev = 1'b0;
    logic mon_rst, mon_rise;
    exp_t mon_e;
    always begin
        @(posedge clk);
        mon_rst     = rst;
        mon_rise    = vsync && !mon_vs_prev;
        mon_vs_prev = vsync;
        #1;
        if (mon_rst) begin
            check("reset_levels", {r_mean, gr_mean, gb_mean, b_mean}, 32'd0);
            check("reset_valid", 32'(mean_valid), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_abort", 32'(abort), 32'd0);
            mon_last = '0;
        end else if (mon_rise) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame_end: no expectation queued at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("eof_abort", 32'(abort), 32'(mon_e.abort));
                check("eof_valid", 32'(mean_valid), 32'(mon_e.valid));
                check("eof_rMean", 32'(r_mean), 32'(mon_e.r));
                check("eof_grMean", 32'(gr_mean), 32'(mon_e.gr));
                check("eof_gbMean", 32'(gb_mean), 32'(mon_e.gb));
                check("eof_bMean", 32'(b_mean), 32'(mon_e.b));
                check("eof_busy", 32'(busy), 32'd0);
                mon_last       = mon_e;
                mon_last.abort = 1'b0;
            end
        end else begin
            check("hold_abort", 32'(abort), 32'd0);
            check("hold_levels", {r_mean, gr_mean, gb_mean, b_mean},
                  {mon_last.r, mon_last.gr, mon_last.gb, mon_last.b});
            check("hold_valid", 32'(mean_valid), 32'(mon_last.valid));
        end
    end

    // End of frame: predict the DUT reaction, then raise vsync.
    task automatic raise_vsync();
        exp_t e;
        int   meas;
        e.abort = 1'b0;
        if (m_armed) begin
            if (m_lines >= OB) begin
                for (int ch = 0; ch < 4; ch++) begin
                    meas = m_sum[ch] / NPIX;
                    if (manual_en) begin
                        m_lvl[ch] = man_of(ch);
                    end else begin
`ifdef BLC_OB_CTRL_IIR_EN
                        m_lvl[ch] = m_valid ? m_lvl[ch] + floor_div4(meas - m_lvl[ch]) : meas;
`else
                        m_lvl[ch] = meas;
`endif
                    end
                end
                m_valid = 1;
            end else begin
                e.abort = 1'b1;
            end
        end
        m_armed = 0;
        e.valid = m_valid;
        e.r     = 8'(m_lvl[0]);
        e.gr    = 8'(m_lvl[1]);
        e.gb    = 8'(m_lvl[2]);
        e.b     = 8'(m_lvl[3]);
        exp_q.push_back(e);
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0 random, 1 per-channel constants, 2 R alternating 10/13, 3 all = cval
    task automatic run_frame(input int lines, input int mode, input int cval, input bit rst_mid);
        int ridx, ch, pix;
        ridx = 0;
        @(negedge clk);
        vsync   = 1'b0;
        m_armed = 1;
        m_lines = 0;
        for (int i = 0; i < 4; i++) m_sum[i] = 0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < W; c++) begin
                @(negedge clk);
                if (c == 0) check("busy_line_start", 32'(busy), 32'(m_armed && l < OB));
                ch = BF ^ (((l & 1) << 1) | (c & 1));
                case (mode)
                    1: pix = (ch == 0) ? 16 : (ch == 1) ? 20 : (ch == 2) ? 24 : 12;
                    2: begin
                        if (ch == 0) begin
                            pix = (ridx % 2 == 0) ? 10 : 13;
                            ridx++;
                        end else begin
                            pix = int'($urandom_range(0, 255));
                        end
                    end
                    3: pix = cval;
                    default: pix = int'($urandom_range(0, 255));
                endcase
                href  = 1'b1;
                pixel = 8'(pix);
                if (l < OB) m_sum[ch] += pix;
            end
            @(negedge clk);
            href  = 1'b0;
            pixel = 8'd0;
            m_lines++;
            @(negedge clk);
            if (rst_mid && l == 0) begin
                rst = 1'b1;
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        raise_vsync();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        href      = 1'b0;
        vsync     = 1'b0;
        pixel     = 8'd0;
        manual_en = 1'b0;
        r_man     = 8'd0;
        gr_man    = 8'd0;
        gb_man    = 8'd0;
        b_man     = 8'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        raise_vsync();                   // rise in IDLE: ignored
        run_frame(H, 1, 0, 1'b0);        // constant OB levels 16/20/24/12
        run_frame(H, 2, 0, 1'b0);        // R alternates 10/13 -> truncated 11
        run_frame(1, 0, 0, 1'b0);        // short frame -> abort, levels retained

        manual_en = 1'b1;
        r_man     = 8'd5;
        gr_man    = 8'($urandom_range(0, 255));
        gb_man    = 8'($urandom_range(0, 255));
        b_man     = 8'($urandom_range(0, 255));
        run_frame(H, 0, 0, 1'b0);        // manual levels load at frame end only
        manual_en = 1'b0;
        run_frame(H, 0, 0, 1'b0);

        run_frame(H, 0, 0, 1'b1);        // reset mid-accumulation, no update this frame
        run_frame(H, 0, 0, 1'b0);        // next full frame updates normally

        do_reset();
        run_frame(H, 3, 0, 1'b0);
        run_frame(H, 3, 40, 1'b0);
        run_frame(H, 3, 40, 1'b0);

        for (int f = 0; f < 10; f++) begin
            manual_en = ($urandom_range(0, 3) == 0);
            r_man     = 8'($urandom_range(0, 255));
            gr_man    = 8'($urandom_range(0, 255));
            gb_man    = 8'($urandom_range(0, 255));
            b_man     = 8'($urandom_range(0, 255));
            run_frame(int'($urandom_range(1, H)), 0, 0, 1'b0);
        end
        manual_en = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blc_ob_ctrl.md
BLC_OB_CTRL -- requirements
Module: blc_ob_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): bits, 8, pixel width; width, 2048, pixels per line, power of two; height, 2048, lines per frame; bayerFormat, 0, 0:RGGB 1:GRBG 2:GBRG 3:BGGR; OB_ROWS, 4, optical-black lines at frame top, power of two >=2.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- href_i  in  1  DVP line valid
- vsync_i  in  1  DVP frame sync, high between frames
- pixel_i  in  bits  raw Bayer pixel
- manual_en_i  in  1  select manual black levels
- rMan_i, grMan_i, gbMan_i, bMan_i  in  bits  manual levels
- rMean_o, grMean_o, gbMean_o, bMean_o  out  bits  black levels driving the BLC mean inputs
- mean_valid_o  out  1  at least one update applied since reset
- busy_o  out  1  OB accumulation in progress
- abort_o  out  1  one-cycle pulse: frame ended before OB_ROWS lines

Function
REQ-004 SHALL classify each pixel with the BLC scheme: column parity toggles every href_i-high cycle and clears when href_i is low; row parity toggles on href_i falling edge and clears while vsync_i is high; channel = bayerFormat ^ {row, col}, where 00 R, 01 Gr, 10 Gb, 11 B.
REQ-005 SHALL implement FSM IDLE -> ACC -> WAIT_EOF -> UPDATE -> IDLE.
REQ-006 IDLE: on vsync_i falling edge -> ACC; clear all four accumulators and the line counter.
REQ-007 ACC: every cycle with href_i=1, add pixel_i to the accumulator of its channel; line counter increments on href_i falling edge; when the counter reaches OB_ROWS -> WAIT_EOF.
REQ-008 ACC: vsync_i rising edge before OB_ROWS lines -> IDLE, pulse abort_o for one cycle, leave outputs unchanged.
REQ-009 WAIT_EOF: on vsync_i rising edge -> UPDATE.
REQ-010 UPDATE (one cycle): measured mean = accumulator >> S, with S = log2(OB_ROWS*width/4); truncate, no rounding. Register outputs in the same cycle; set mean_valid_o=1.
REQ-011 Accumulators SHALL be bits+S wide and never overflow.
REQ-012 With manual_en_i=1 sampled in UPDATE, outputs SHALL load the *Man_i values instead of the measurement; accumulation still runs.
REQ-013 Outputs SHALL change only in UPDATE, so the BLC never sees a mid-frame level change.
REQ-014 busy_o SHALL be 1 exactly while in ACC.
REQ-015 A vsync_i rising edge observed in IDLE SHALL be ignored.

Reset
REQ-016 With rst=1 at a clock edge: FSM -> IDLE; accumulators, counters and parities -> 0; all *Mean_o -> 0; mean_valid_o, busy_o, abort_o -> 0.
REQ-017 Reset asserted mid-ACC SHALL discard partial sums; the first update requires a full vsync_i falling-to-rising cycle after release.

Configuration
REQ-018 Macro BLC_OB_CTRL_IIR_EN defined: measured update SHALL be out = out + ((meas - out) >>> 2), computed signed in bits+1 and result in range; the first update after reset loads meas directly. Manual values always load directly.
REQ-019 Macro undefined: out = meas directly; no IIR logic SHALL be present.

Structure
REQ-020 Shared package blc_pkg SHALL hold the FSM state typedef, the channel encoding constants (R/GR/GB/B) and the bayerFormat constants.
REQ-021 Sub-module blc_bayer_pos SHALL own the row/column parity and channel decode, reusable by the BLC.

Verification (bits=8, width=16, height=8, OB_ROWS=2, S=3, RGGB)
REQ-022 OB lines R=16, Gr=20, Gb=24, B=12 constant -> on cycle after vsync_i rise: outputs 16/20/24/12, mean_valid_o=1.
REQ-023 R pixels alternate 10/13 in OB lines (sum 92) -> rMean_o=11 (truncated).
REQ-024 vsync_i rises after 1 OB line -> abort_o single pulse, outputs retain prior values.
REQ-025 manual_en_i=1, rMan_i=5 -> rMean_o=5 at next UPDATE, not earlier.
REQ-026 rst pulsed mid-ACC -> all outputs 0 next cycle; next full frame updates normally.
REQ-027 IIR_EN: out=0 after an update with meas 0, then meas 40 -> out=10, then 17.
